ctrl_frame_tx: RTL

CTRL_FRAME_TX -- requirements
Module: ctrl_frame_tx

---
 rtl/ctrl_link_pkg.sv | 21 ++
 rtl/ctrl_frame_tx_if.sv | 17 +
 rtl/ctrl_frame_tx_baud_gen.sv | 31 +++
 rtl/ctrl_frame_tx.sv | 123 ++++++++++++
 4 files changed

// File: rtl/ctrl_link_pkg.sv
// Constants and the FSM state type for the serial control link.
// The transmitter and the a_ctrls receiver both import this package.
package ctrl_link_pkg;

  localparam logic [7:0] SYNC_BYTE    = 8'hA5;
  localparam int         N_CH_DEFAULT = 7;
  localparam int         FRAME_BYTES  = N_CH_DEFAULT + 2;

  typedef enum logic [1:0] {
    IDLE,
    START_BIT,
    DATA_BIT,
    STOP_BIT
  } tx_state_e;

  // A frame is SYNC, one byte per channel, then the checksum.
  function automatic int frame_bytes(input int n_ch);
    return n_ch + 2;
  endfunction

endpackage

// File: rtl/ctrl_frame_tx_if.sv
// Frame request and serial status bundle between a controller and ctrl_frame_tx.
interface ctrl_frame_tx_if
  import ctrl_link_pkg::*;
#(
  parameter int N_CH = N_CH_DEFAULT
);

  logic [7:0] ch_data [N_CH];
  logic       start;
  logic       CTRL_TX;
  logic       busy;
  logic       done;

  modport master (output ch_data, start, input CTRL_TX, busy, done);
  modport slave  (input ch_data, start, output CTRL_TX, busy, done);

endinterface

// File: rtl/ctrl_frame_tx_baud_gen.sv
// Bit-period counter: tick is high for one cycle on the last clk of every bit.
// restart holds the counter at zero so that the first bit is a full period long.
module baud_gen #(
  parameter int BAUD_DIV = 434
) (
  input  logic clk,
  input  logic reset_n,
  input  logic restart,
  output logic tick
);

  localparam int            CW   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] cnt;

  // NOTE: non-blocking assignments make every flop sample its pre-edge inputs,
  // so the result does not depend on the order in which blocks are evaluated.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (restart || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = !restart && (cnt == LAST);

endmodule

// File: rtl/ctrl_frame_tx.sv
// Serialises SYNC, N_CH channel bytes and a modulo-256 checksum as 8N1 frames.
// CTRL_TX, busy and done all come straight from flops.
module ctrl_frame_tx
  import ctrl_link_pkg::*;
#(
  parameter int fCLK  = 50_000_000,
  parameter int fBAUD = 115_200,
  parameter int N_CH  = N_CH_DEFAULT
) (
  input  logic            clk,
  input  logic            reset_n,
  ctrl_frame_tx_if.slave  bus
);

  localparam int            BAUD_DIV  = fCLK / fBAUD;
  localparam int            N_BYTES   = frame_bytes(N_CH);
  localparam int            BW        = $clog2(N_BYTES);
  localparam logic [BW-1:0] LAST_BYTE = BW'(N_BYTES - 1);

  tx_state_e     state;
  logic [7:0]    snap [N_CH];
  logic [BW-1:0] byte_idx;
  logic [2:0]    bit_idx;
  logic [7:0]    chk;
  logic [7:0]    cur_byte;
  logic          tick;
  logic          tx_q;
  logic          busy_q;
  logic          done_q;

  baud_gen #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud (
    .clk     (clk),
    .reset_n (reset_n),
    .restart (state == IDLE),
    .tick    (tick)
  );

  // NOTE: every variable gets a default at the top of the block so that no
  // path through it leaves a value unassigned and infers a latch.
  always_comb begin
    chk      = '0;
    cur_byte = SYNC_BYTE;
    for (int i = 0; i < N_CH; i++) begin
      chk = chk + snap[i];
    end
    if (byte_idx == LAST_BYTE) begin
      cur_byte = chk;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (byte_idx == BW'(i + 1)) cur_byte = snap[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      // NOTE: the snapshot is a handful of flops, not a RAM, so it is cleared
      // with the rest of the state; a real memory array would be left unreset.
      snap     <= '{default: '0};
      byte_idx <= '0;
      bit_idx  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            snap     <= bus.ch_data;
            byte_idx <= '0;
            bit_idx  <= '0;
            tx_q     <= 1'b0;
            busy_q   <= 1'b1;
            state    <= START_BIT;
          end
        end
        START_BIT: begin
          if (tick) begin
            bit_idx <= '0;
            tx_q    <= cur_byte[0];
            state   <= DATA_BIT;
          end
        end
        DATA_BIT: begin
          if (tick) begin
            if (bit_idx == 3'd7) begin
              tx_q  <= 1'b1;
              state <= STOP_BIT;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx_q    <= cur_byte[bit_idx + 3'd1];
            end
          end
        end
        STOP_BIT: begin
          if (tick) begin
            if (byte_idx == LAST_BYTE) begin
              byte_idx <= '0;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              state    <= IDLE;
            end else begin
              // Next start bit follows the stop bit with no idle gap.
              byte_idx <= byte_idx + 1'b1;
              tx_q     <= 1'b0;
              state    <= START_BIT;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.CTRL_TX = tx_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule
